// File: rtl/toysram_pkg.sv
// rtl/toysram_pkg.sv - shared constants and state encoding for the toysram scan sequencer
package toysram_pkg;

  // Length of the RA0 configuration scan chain
  localparam int SCAN_LEN_DEFAULT = 128;

  // Sequencer states: idle, scan clock low/high phases, and the hold tail before te drops
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_TAIL = 2'd3
  } scan_state_e;

  // Recognisable test vector for bring-up and loopback checks
  localparam logic [127:0] SCAN_INIT = 128'h0123456789ABCDEFFEDCBA9876543210;

endpackage

// File: rtl/toysram_scan_phase.sv
// rtl/toysram_scan_phase.sv - reloadable down-counter timing one scan clock phase
module toysram_scan_phase #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_capture,
  input  logic [W-1:0] i_div,
  input  logic         i_reload,
  input  logic         i_count,
  output logic         o_expire
);

  logic [W-1:0] r_div_q;
  logic [W-1:0] r_phase_cnt;

  // Capture a new period, restart a phase from the held period, or count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_q     <= '0;
      r_phase_cnt <= '0;
    end else if (i_capture) begin
      r_div_q     <= i_div;
      r_phase_cnt <= i_div;
    end else if (i_reload) begin
      r_phase_cnt <= r_div_q;
    end else if (i_count && (r_phase_cnt != '0)) begin
      r_phase_cnt <= r_phase_cnt - 1'b1;
    end
  end

  assign o_expire = (r_phase_cnt == '0);

endmodule

// File: rtl/toysram_scan_ctl.sv
// rtl/toysram_scan_ctl.sv - scan-chain sequencer driving TE/SCAN_CLK/SCAN_IN of the RA0 macro
module toysram_scan_ctl
  import toysram_pkg::*;
#(
  parameter int SCAN_LEN = SCAN_LEN_DEFAULT,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIV_W-1:0]    div,
  input  logic [SCAN_LEN-1:0] din,
  output logic                busy,
  output logic                done,
  output logic [SCAN_LEN-1:0] dout,
  output logic                te,
  output logic                scan_clk,
  output logic                scan_in,
  input  logic                scan_out
);

  localparam int CW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SCAN_LEN - 1);

  scan_state_e         r_state;
  scan_state_e         w_state_nxt;
  logic [CW-1:0]       r_bit_cnt;
  logic [SCAN_LEN-1:0] r_sin;
  logic [SCAN_LEN-1:0] r_dout;
  logic                r_te;
  logic                r_scan_clk;
  logic                r_busy;
  logic                r_done;
  logic                r_tail_extra;
  logic                w_capture;
  logic                w_reload;
  logic                w_count;
  logic                w_sample;
  logic                w_done_nxt;
  logic                w_expire;

  toysram_scan_phase #(.W(DIV_W)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_div     (div),
    .i_reload  (w_reload),
    .i_count   (w_count),
    .o_expire  (w_expire)
  );

  // Next-state and per-cycle strobes; abort overrides everything while busy
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_reload    = 1'b0;
    w_count     = 1'b0;
    w_sample    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_expire) begin
          w_reload    = 1'b1;
          w_state_nxt = ST_HIGH;
        end else begin
          w_count = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_expire) begin
          w_reload    = 1'b1;
          w_sample    = 1'b1;
          w_state_nxt = (r_bit_cnt == LAST_BIT) ? ST_TAIL : ST_LOW;
        end else begin
          w_count = 1'b1;
        end
      end
      ST_TAIL: begin
        // The hold window is div+1 cycles; one extra settle cycle follows before done
        if (w_expire) begin
          if (r_tail_extra) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_count = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_sample    = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  // State and registered pin outputs, all derived from the next state so pins move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_te         <= 1'b0;
      r_busy       <= 1'b0;
      r_scan_clk   <= 1'b0;
      r_done       <= 1'b0;
      r_tail_extra <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_te         <= (w_state_nxt != ST_IDLE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_scan_clk   <= (w_state_nxt == ST_HIGH);
      r_done       <= w_done_nxt;
      r_tail_extra <= (r_state == ST_TAIL) && (w_state_nxt == ST_TAIL) &&
                      (w_expire || r_tail_extra);
    end
  end

  // Shift-in/shift-out registers and bit counter; both shift at the end of each HIGH phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin     <= '0;
      r_dout    <= '0;
      r_bit_cnt <= '0;
    end else if (w_capture) begin
      r_sin     <= din;
      r_bit_cnt <= '0;
    end else if (w_sample) begin
      r_sin  <= {1'b0, r_sin[SCAN_LEN-1:1]};
      r_dout <= {scan_out, r_dout[SCAN_LEN-1:1]};
      if (r_bit_cnt != LAST_BIT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign dout     = r_dout;
  assign te       = r_te;
  assign scan_clk = r_scan_clk;
  assign scan_in  = r_sin[0];

endmodule

// File: tb/tb_toysram_scan_ctl.sv
// tb/tb_toysram_scan_ctl.sv - directed self-checking bench for toysram_scan_ctl with a loopback chain
module tb_toysram_scan_ctl;
  import toysram_pkg::*;

  localparam int L  = 128;
  localparam int DW = 8;

  localparam logic [L-1:0] P_A5 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [L-1:0] P_0F = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [L-1:0] P_AB = 128'hDEADBEEF_CAFEF00D_01020304_05060708;
  localparam logic [L-1:0] P_RS = 128'h13579BDF_2468ACE0_FFFF0000_0000FFFF;
  localparam logic [L-1:0] P_B1 = 128'h80000000_00000000_00000000_00000001;
  localparam logic [L-1:0] P_B2 = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] div;
  logic [L-1:0]  din;
  logic          busy;
  logic          done;
  logic [L-1:0]  dout;
  logic          te;
  logic          scan_clk;
  logic          scan_in;
  logic          scan_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  toysram_scan_ctl #(.SCAN_LEN(L), .DIV_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .div      (div),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .te       (te),
    .scan_clk (scan_clk),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  // Macro model: 128-bit chain shifting on scan_clk rise, tail through a lockup latch
  logic [L-1:0] chain  = '0;
  logic         tail_q = 1'b0;
  always @(posedge scan_clk) begin
    tail_q <= chain[0];
    chain  <= {scan_in, chain[L-1:1]};
  end
  assign scan_out = scan_clk ? tail_q : chain[0];

  // Called at a negedge: present a start request, return at the negedge after the accept edge
  task automatic launch(input logic [L-1:0] d, input logic [DW-1:0] dv);
    din   = d;
    div   = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow a sequence until done, optionally poking start/din/div mid-run; lat=-1 on timeout
  task automatic run_wait(input int poke_a, input int poke_b, input int div_chg,
                          output int lat, output int nrise, output int te_low,
                          output int gmin, output int gmax);
    logic prev_sc;
    int   last_rise;
    lat = 0; nrise = 0; te_low = 0; gmin = 1000000; gmax = 0;
    last_rise = -1;
    prev_sc = scan_clk;
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_a) || (lat == poke_b);
      if (lat == poke_a) din = ~din;
      if (lat == div_chg) div = '0;
      if (done) break;
      if (!te) te_low++;
      if (scan_clk && !prev_sc) begin
        nrise++;
        if (last_rise >= 0) begin
          if (lat - last_rise < gmin) gmin = lat - last_rise;
          if (lat - last_rise > gmax) gmax = lat - last_rise;
        end
        last_rise = lat;
      end
      prev_sc = scan_clk;
    end
    start = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; div = '0; din = '0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({busy, done, te, scan_clk, scan_in} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_ctl got %b exp 00000", {busy, done, te, scan_clk, scan_in});
    end
    vec_cnt++;
    if (dout !== '0) begin
      err_cnt++;
      $display("FAIL reset_dout got %h exp 0", dout);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({busy, te, scan_clk} !== 3'b0) begin
      err_cnt++;
      $display("FAIL idle_after_reset got %b exp 000", {busy, te, scan_clk});
    end
  endtask

  task automatic test_basic();
    int lat, nr, tl, gmin, gmax;
    @(negedge clk);
    launch(SCAN_INIT, 8'd0);
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 258) begin err_cnt++; $display("FAIL basic_latency got %0d exp 258", lat); end
    vec_cnt++; if (dout !== '0) begin err_cnt++; $display("FAIL basic_dout got %h exp 0", dout); end
    vec_cnt++; if (tl !== 0) begin err_cnt++; $display("FAIL basic_te_low got %0d exp 0", tl); end
    vec_cnt++; if (nr !== 128) begin err_cnt++; $display("FAIL basic_rises got %0d exp 128", nr); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    vec_cnt++; if (chain !== SCAN_INIT) begin err_cnt++; $display("FAIL basic_chain got %h exp %h", chain, SCAN_INIT); end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL done_one_cycle got %b exp 0", done); end
    launch('1, 8'd0);
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 258) begin err_cnt++; $display("FAIL ones_latency got %0d exp 258", lat); end
    vec_cnt++; if (dout !== SCAN_INIT) begin err_cnt++; $display("FAIL ones_dout got %h exp %h", dout, SCAN_INIT); end
    vec_cnt++; if (chain !== '1) begin err_cnt++; $display("FAIL ones_chain got %h exp all ones", chain); end
  endtask

  task automatic test_div3();
    int lat, nr, tl, gmin, gmax;
    @(negedge clk);
    launch(P_A5, 8'd3);
    run_wait(-1, -1, 50, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 1029) begin err_cnt++; $display("FAIL div3_latency got %0d exp 1029", lat); end
    vec_cnt++; if (nr !== 128) begin err_cnt++; $display("FAIL div3_rises got %0d exp 128", nr); end
    vec_cnt++; if (gmin !== 8 || gmax !== 8) begin err_cnt++; $display("FAIL div3_period got %0d..%0d exp 8..8", gmin, gmax); end
    vec_cnt++; if (dout !== '1) begin err_cnt++; $display("FAIL div3_dout got %h exp all ones", dout); end
    vec_cnt++; if (chain !== P_A5) begin err_cnt++; $display("FAIL div3_chain got %h exp %h", chain, P_A5); end
  endtask

  task automatic test_start_busy();
    int lat, nr, tl, gmin, gmax, extra;
    @(negedge clk);
    launch(P_0F, 8'd1);
    run_wait(10, 100, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 515) begin err_cnt++; $display("FAIL busy_start_latency got %0d exp 515", lat); end
    vec_cnt++; if (chain !== P_0F) begin err_cnt++; $display("FAIL busy_start_chain got %h exp %h", chain, P_0F); end
    vec_cnt++; if (dout !== P_A5) begin err_cnt++; $display("FAIL busy_start_dout got %h exp %h", dout, P_A5); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vec_cnt++; if (extra !== 0) begin err_cnt++; $display("FAIL busy_start_single got %0d extra cycles exp 0", extra); end
  endtask

  task automatic test_abort();
    int lat, nr, tl, gmin, gmax, rises, guard, stray;
    logic prev_sc;
    logic [L-1:0] snap;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    vec_cnt++; if ({busy, te} !== 2'b00) begin err_cnt++; $display("FAIL abort_beats_start got %b exp 00", {busy, te}); end
    launch(P_AB, 8'd0);
    rises = 0; guard = 0; prev_sc = scan_clk;
    while (rises < 40 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (scan_clk && !prev_sc) rises++;
      prev_sc = scan_clk;
    end
    vec_cnt++; if (rises !== 40) begin err_cnt++; $display("FAIL abort_reach40 got %0d exp 40", rises); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vec_cnt++;
    if ({te, scan_clk, busy, done} !== 4'b0) begin
      err_cnt++;
      $display("FAIL abort_next_cycle got %b exp 0000", {te, scan_clk, busy, done});
    end
    stray = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    vec_cnt++; if (stray !== 0) begin err_cnt++; $display("FAIL abort_no_done got %0d exp 0", stray); end
    snap = chain;
    launch(P_B1, 8'd0);
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 258) begin err_cnt++; $display("FAIL post_abort_latency got %0d exp 258", lat); end
    vec_cnt++; if (dout !== snap) begin err_cnt++; $display("FAIL post_abort_dout got %h exp %h", dout, snap); end
    vec_cnt++; if (chain !== P_B1) begin err_cnt++; $display("FAIL post_abort_chain got %h exp %h", chain, P_B1); end
  endtask

  task automatic test_reset_mid();
    int lat, nr, tl, gmin, gmax, rises, guard;
    logic prev_sc;
    logic [L-1:0] snap;
    @(negedge clk);
    launch(P_RS, 8'd2);
    rises = 0; guard = 0; prev_sc = scan_clk;
    while (!(rises >= 10 && scan_clk) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (scan_clk && !prev_sc) rises++;
      prev_sc = scan_clk;
    end
    vec_cnt++; if (scan_clk !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_reach_high got %b exp 1", scan_clk); end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({te, scan_clk, busy, done, scan_in} !== 5'b0) begin
      err_cnt++;
      $display("FAIL rst_mid_ctl got %b exp 00000", {te, scan_clk, busy, done, scan_in});
    end
    vec_cnt++; if (dout !== '0) begin err_cnt++; $display("FAIL rst_mid_dout got %h exp 0", dout); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    snap = chain;
    launch(P_B2, 8'd2);
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 772) begin err_cnt++; $display("FAIL rst_restart_latency got %0d exp 772", lat); end
    vec_cnt++; if (dout !== snap) begin err_cnt++; $display("FAIL rst_restart_dout got %h exp %h", dout, snap); end
    vec_cnt++; if (chain !== P_B2) begin err_cnt++; $display("FAIL rst_restart_chain got %h exp %h", chain, P_B2); end
  endtask

  task automatic test_back_to_back();
    int lat, nr, tl, gmin, gmax;
    @(negedge clk);
    launch(SCAN_INIT, 8'd0);
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 258) begin err_cnt++; $display("FAIL b2b_first_latency got %0d exp 258", lat); end
    vec_cnt++; if (dout !== P_B2) begin err_cnt++; $display("FAIL b2b_first_dout got %h exp %h", dout, P_B2); end
    launch(P_A5, 8'd0);
    vec_cnt++; if ({busy, te} !== 2'b11) begin err_cnt++; $display("FAIL b2b_accept got %b exp 11", {busy, te}); end
    run_wait(-1, -1, -1, lat, nr, tl, gmin, gmax);
    vec_cnt++; if (lat !== 258) begin err_cnt++; $display("FAIL b2b_second_latency got %0d exp 258", lat); end
    vec_cnt++; if (tl !== 0) begin err_cnt++; $display("FAIL b2b_te_low got %0d exp 0", tl); end
    vec_cnt++; if (dout !== SCAN_INIT) begin err_cnt++; $display("FAIL b2b_second_dout got %h exp %h", dout, SCAN_INIT); end
    vec_cnt++; if (chain !== P_A5) begin err_cnt++; $display("FAIL b2b_chain got %h exp %h", chain, P_A5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
